// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the 2x2 systolic PE array: accepts one job, clears the array, issues skewed
// start pulses, waits for completion (with timeout) and holds both row results until the host takes them.
module systolic_array_ctrl #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    // job input: valid/ready, transfer when in_valid && in_ready on a rising edge
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] in_a,
    input  logic [2*DW-1:0] in_b,
    input  logic [DW-1:0]   in_bias,
    // result output: valid/ready, held stable until out_valid && out_ready on a rising edge
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_row1,
    output logic [DW-1:0]   out_row2,
    output logic            out_err,
    // array side
    output logic [DW-1:0]   a11,
    output logic [DW-1:0]   a12,
    output logic [DW-1:0]   a21,
    output logic [DW-1:0]   a22,
    output logic [DW-1:0]   b1,
    output logic [DW-1:0]   b2,
    output logic [DW-1:0]   prev_operand,
    output logic            start_PE11,
    output logic            start_PE12,
    output logic            start_PE21,
    output logic            start_PE22,
    output logic            clear,
    input  logic            done_PE11,
    input  logic            done_PE22,
    input  logic [DW-1:0]   result_row1,
    input  logic [DW-1:0]   result_row2,
    // debug: current FSM state encoding
    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ISS1 = 3'd2,
        S_ISS2 = 3'd3,
        S_ISS3 = 3'd4,
        S_WAIT = 3'd5,
        S_OUT  = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            seen11_q, seen11_d;
    logic [4*DW-1:0] a_q, a_d;
    logic [2*DW-1:0] b_q, b_d;
    logic [DW-1:0]   bias_q, bias_d;
    logic [DW-1:0]   row1_q, row1_d;
    logic [DW-1:0]   row2_q, row2_d;
    logic            err_q, err_d;
    logic            limit;

    assign limit = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            seen11_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            bias_q   <= '0;
            row1_q   <= '0;
            row2_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen11_q <= seen11_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bias_q   <= bias_d;
            row1_q   <= row1_d;
            row2_q   <= row2_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen11_d = seen11_q;
        a_d      = a_q;
        b_d      = b_q;
        bias_d   = bias_q;
        row1_d   = row1_q;
        row2_d   = row2_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    bias_d   = in_bias;
                    seen11_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_CLR;
                end
            end
            S_CLR:  state_d = S_ISS1;
            S_ISS1: state_d = S_ISS2;
            S_ISS2: state_d = S_ISS3;
            S_ISS3: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_PE11) begin
                    seen11_d = 1'b1;
                end
                // Completion beats the timeout when both land in the same cycle.
                if (done_PE22) begin
                    row1_d  = result_row1;
                    row2_d  = result_row2;
                    err_d   = !(seen11_q || done_PE11);
                    state_d = S_OUT;
                end else if (limit) begin
                    row1_d  = '0;
                    row2_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        clear      = 1'b0;
        start_PE11 = 1'b0;
        start_PE12 = 1'b0;
        start_PE21 = 1'b0;
        start_PE22 = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_CLR:  clear = 1'b1;
            S_ISS1: start_PE11 = 1'b1;
            S_ISS2: begin
                start_PE12 = 1'b1;
                start_PE21 = 1'b1;
            end
            S_ISS3: start_PE22 = 1'b1;
            S_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign a11          = a_q[DW-1:0];
    assign a12          = a_q[2*DW-1:DW];
    assign a21          = a_q[3*DW-1:2*DW];
    assign a22          = a_q[4*DW-1:3*DW];
    assign b1           = b_q[DW-1:0];
    assign b2           = b_q[2*DW-1:DW];
    assign prev_operand = bias_q;
    assign out_row1     = row1_q;
    assign out_row2     = row2_q;
    assign out_err      = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: a job driver pushes expected results into exp_q and a
// monitor pops and compares on each out_valid/out_ready handshake.
module tb_systolic_array_ctrl;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_a;
    logic [2*DW-1:0] in_b;
    logic [DW-1:0]   in_bias;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_row1, out_row2;
    logic            out_err;
    logic [DW-1:0]   a11, a12, a21, a22, b1, b2, prev_operand;
    logic            start_PE11, start_PE12, start_PE21, start_PE22, clear;
    logic            done_PE11, done_PE22;
    logic [DW-1:0]   result_row1, result_row2;
    logic [2:0]      dbg_state_o;

    systolic_array_ctrl #(.DW(DW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row1(out_row1), .out_row2(out_row2), .out_err(out_err),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b1(b1), .b2(b2), .prev_operand(prev_operand),
        .start_PE11(start_PE11), .start_PE12(start_PE12),
        .start_PE21(start_PE21), .start_PE22(start_PE22), .clear(clear),
        .done_PE11(done_PE11), .done_PE22(done_PE22),
        .result_row1(result_row1), .result_row2(result_row2),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic [2*DW:0]   exp_q[$];
    logic [2*DW:0]   last_res = '0;
    logic [7*DW-1:0] last_ops = '0;
    logic [6:0]      ctrl;
    logic [7*DW-1:0] ops;

    always @(posedge clk) cyc <= cyc + 1;

    assign ctrl = {in_ready, out_valid, clear, start_PE11, start_PE12, start_PE21, start_PE22};
    assign ops  = {prev_operand, b2, b1, a22, a21, a12, a11};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // inputs change 1ns after the falling edge, well away from the sampling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] r1, input logic [DW-1:0] r2, input logic err);
        exp_q.push_back({err, r2, r1});
        last_res = {err, r2, r1};
    endtask

    // driver: offer a job, wait for acceptance, check clear/start pulse sequence up to WAIT entry
    task automatic accept_job(input logic [4*DW-1:0] a, input logic [2*DW-1:0] b,
                              input logic [DW-1:0] bias, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_bias  = bias;
        while (!in_ready && waits < 200) begin
            tick();
            waits++;
        end
        check("accept_ready", in_ready, 1'b1);
        check("ops_hold_idle", ops, last_ops);
        check("res_retain_idle", {out_err, out_row2, out_row1}, last_res);
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = $urandom;
        in_bias  = DW'($urandom);
        last_ops = {bias, b, a};
        check("clr_ctrl", ctrl, 7'b0010000);
        check("clr_ops", ops, last_ops);
        tick();
        check("iss1_ctrl", ctrl, 7'b0001000);
        tick();
        check("iss2_ctrl", ctrl, 7'b0000110);
        tick();
        check("iss3_ctrl", ctrl, 7'b0000001);
        tick();
        check("wait_ctrl", ctrl, 7'b0000000);
    endtask

    // array model: done_PE22 in WAIT cycle done_lat (-1 = never), done_PE11 in WAIT cycle 0 if d11
    task automatic wait_done(input int done_lat, input bit d11, input logic [DW-1:0] r1,
                             input logic [DW-1:0] r2, input int exp_k);
        int k = 0;
        while (!out_valid && k < 200) begin
            done_PE22   = (k == done_lat);
            done_PE11   = d11 && (k == 0);
            result_row1 = (k == done_lat) ? r1 : 16'hDEAD;
            result_row2 = (k == done_lat) ? r2 : 16'hBEEF;
            tick();
            k++;
        end
        done_PE22 = 1'b0;
        done_PE11 = 1'b0;
        check("wait_latency", k, exp_k);
        check("ops_stable_out", ops, last_ops);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [2*DW:0] e;
        #2;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_result", {out_err, out_row2, out_row1}, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waits;
        int t1;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_bias     = '0;
        out_ready   = 1'b1;
        done_PE11   = 1'b0;
        done_PE22   = 1'b0;
        result_row1 = '0;
        result_row2 = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ctrl", ctrl, 7'b1000000);
        check("rst_res", {out_err, out_row2, out_row1}, '0);
        check("rst_ops", ops, '0);
        check("rst_state", dbg_state_o, 3'd0);

        // single job
        accept_job({16'd4, 16'd3, 16'd2, 16'd1}, {16'd6, 16'd5}, 16'd0, waits);
        push_exp(16'h0011, 16'h0022, 1'b0);
        wait_done(3, 1'b1, 16'h0011, 16'h0022, 4);
        tick();

        // timeout: no done_PE22
        accept_job({16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d}, {16'h1111, 16'h2222}, 16'h0007, waits);
        push_exp(16'h0000, 16'h0000, 1'b1);
        wait_done(-1, 1'b1, 16'h0, 16'h0, 64);
        tick();

        // done_PE22 on the limit cycle wins
        accept_job({16'h0001, 16'h0001, 16'h0001, 16'h0001}, {16'h0002, 16'h0002}, 16'h0003, waits);
        push_exp(16'h7777, 16'h8888, 1'b0);
        wait_done(63, 1'b1, 16'h7777, 16'h8888, 64);
        tick();

        // missing done_PE11
        accept_job({16'h0040, 16'h0030, 16'h0020, 16'h0010}, {16'h0060, 16'h0050}, 16'h0099, waits);
        push_exp(16'h0101, 16'h0202, 1'b1);
        wait_done(1, 1'b0, 16'h0101, 16'h0202, 2);
        tick();

        // backpressure, done_PE11 and done_PE22 together in WAIT cycle 0
        out_ready = 1'b0;
        accept_job({16'h1234, 16'h5678, 16'h9abc, 16'hdef0}, {16'hcafe, 16'hf00d}, 16'h0042, waits);
        push_exp(16'haaaa, 16'h5555, 1'b0);
        wait_done(0, 1'b1, 16'haaaa, 16'h5555, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_rows", {out_err, out_row2, out_row1}, {1'b0, 16'h5555, 16'haaaa});
            check("bp_in_ready", in_ready, 1'b0);
            in_valid = 1'b1;
            in_a     = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
            tick();
        end
        out_ready = 1'b1;
        accept_job({16'h0004, 16'h0003, 16'h0002, 16'h0001}, {16'h0006, 16'h0005}, 16'h0001, waits);
        check("bp_accept_wait", waits, 1);
        push_exp(16'h1234, 16'h5678, 1'b0);
        wait_done(1, 1'b1, 16'h1234, 16'h5678, 2);
        tick();

        // reset mid-WAIT, then a late done_PE22
        accept_job({16'h0bad, 16'h0bad, 16'h0bad, 16'h0bad}, {16'h0bad, 16'h0bad}, 16'h0bad, waits);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_res = '0;
        last_ops = '0;
        check("midrst_ctrl", ctrl, 7'b1000000);
        check("midrst_state", dbg_state_o, 3'd0);
        check("midrst_res", {out_err, out_row2, out_row1}, '0);
        check("midrst_ops", ops, '0);
        done_PE22   = 1'b1;
        done_PE11   = 1'b1;
        result_row1 = 16'h5a5a;
        result_row2 = 16'ha5a5;
        tick();
        done_PE22 = 1'b0;
        done_PE11 = 1'b0;
        tick();
        check("late_done_ctrl", ctrl, 7'b1000000);
        check("late_done_res", {out_err, out_row2, out_row1}, '0);

        // back-to-back with out_ready high
        accept_job({16'h0011, 16'h0022, 16'h0033, 16'h0044}, {16'h0055, 16'h0066}, 16'h0077, waits);
        t1 = acc_cyc;
        push_exp(16'h0abc, 16'h0def, 1'b0);
        wait_done(2, 1'b1, 16'h0abc, 16'h0def, 3);
        accept_job({16'h1100, 16'h2200, 16'h3300, 16'h4400}, {16'h5500, 16'h6600}, 16'h7700, waits);
        check("b2b_spacing", acc_cyc - t1, 9);
        push_exp(16'hfedc, 16'hba98, 1'b0);
        wait_done(4, 1'b1, 16'hfedc, 16'hba98, 5);
        repeat (3) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
